// File: rtl/regfile_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 16;

    typedef logic [DATA_W_DEF-1:0]         reg_data_t;
    typedef logic [$clog2(DEPTH_DEF)-1:0]  reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending bits for multi-cycle producers, with a registered popcount.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              resvEnable,
    input  logic [ADDR_W-1:0] resvAddress,
    input  logic              wrEnable0,
    input  logic [ADDR_W-1:0] wrAddress0,
    input  logic              wrEnable1,
    input  logic [ADDR_W-1:0] wrAddress1,
    output logic [DEPTH-1:0]  pending,
    output logic [ADDR_W:0]   pendingCount
);

    logic [DEPTH-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  count_q, count_d;

    // Reserve is applied after the clears so a retiring write cannot drop a new reservation.
    always_comb begin
        pend_d = pend_q;
        if (wrEnable0) pend_d[wrAddress0] = 1'b0;
        if (wrEnable1) pend_d[wrAddress1] = 1'b0;
        if (resvEnable) pend_d[resvAddress] = 1'b1;
        if (ZERO_REG) pend_d[0] = 1'b0;
    end

    always_comb begin
        count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_d = count_d + {{ADDR_W{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            count_q <= '0;
        end else begin
            pend_q  <= pend_d;
            count_q <= count_d;
        end
    end

    assign pending      = pend_q;
    assign pendingCount = count_q;

endmodule

// File: rtl/reg_file_sb.sv
// Two-write, two-read register file with optional bypass, optional zero register,
// and a pending scoreboard for stalling dependent instructions.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned ADDR_W   = $clog2(DEPTH),
    parameter bit          BYPASS   = 1'b1,
    parameter bit          ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWriteEnable0,
    input  logic [ADDR_W-1:0] regWriteAddress0,
    input  logic [DATA_W-1:0] regWriteData0,
    input  logic              regWriteEnable1,
    input  logic [ADDR_W-1:0] regWriteAddress1,
    input  logic [DATA_W-1:0] regWriteData1,
    input  logic [ADDR_W-1:0] regReadAddress1,
    input  logic [ADDR_W-1:0] regReadAddress2,
    output logic [DATA_W-1:0] regReadData1,
    output logic [DATA_W-1:0] regReadData2,
    input  logic              resvEnable,
    input  logic [ADDR_W-1:0] resvAddress,
    output logic              regPending1,
    output logic              regPending2,
    output logic [ADDR_W:0]   pendingCount
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic [DEPTH-1:0]  pending;

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        if (regWriteEnable0) mem_d[regWriteAddress0] = regWriteData0;
        if (regWriteEnable1) mem_d[regWriteAddress1] = regWriteData1;
        if (ZERO_REG) mem_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_addr[0] = regReadAddress1;
    assign rd_addr[1] = regReadAddress2;

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            rd_data[p] = mem_q[rd_addr[p]];
            if (BYPASS) begin
                if (regWriteEnable0 && regWriteAddress0 == rd_addr[p]) rd_data[p] = regWriteData0;
                if (regWriteEnable1 && regWriteAddress1 == rd_addr[p]) rd_data[p] = regWriteData1;
            end
            if (ZERO_REG && rd_addr[p] == '0) rd_data[p] = '0;
        end
    end

    assign regReadData1 = rd_data[0];
    assign regReadData2 = rd_data[1];

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .resvEnable   (resvEnable),
        .resvAddress  (resvAddress),
        .wrEnable0    (regWriteEnable0),
        .wrAddress0   (regWriteAddress0),
        .wrEnable1    (regWriteEnable1),
        .wrAddress1   (regWriteAddress1),
        .pending      (pending),
        .pendingCount (pendingCount)
    );

    assign regPending1 = pending[regReadAddress1];
    assign regPending2 = pending[regReadAddress2];

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypass build and a no-bypass zero-register build share stimulus.
module tb_reg_file_sb;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      reset;
    logic      we0, we1, resv;
    reg_addr_t wa0, wa1, ra1, ra2, rsa;
    reg_data_t wd0, wd1;

    reg_data_t  rd1_a, rd2_a, rd1_b, rd2_b;
    logic       p1_a, p2_a, p1_b, p2_b;
    logic [4:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 = bypass build, index 1 = no-bypass zero-register build.
    logic [7:0] mem_m  [2][16];
    bit         pend_m [2][16];

    always #5 clk = ~clk;

    reg_file_sb #(.BYPASS(1'b1), .ZERO_REG(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .regWriteEnable0(we0), .regWriteAddress0(wa0), .regWriteData0(wd0),
        .regWriteEnable1(we1), .regWriteAddress1(wa1), .regWriteData1(wd1),
        .regReadAddress1(ra1), .regReadAddress2(ra2),
        .regReadData1(rd1_a), .regReadData2(rd2_a),
        .resvEnable(resv), .resvAddress(rsa),
        .regPending1(p1_a), .regPending2(p2_a), .pendingCount(cnt_a)
    );

    reg_file_sb #(.BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .regWriteEnable0(we0), .regWriteAddress0(wa0), .regWriteData0(wd0),
        .regWriteEnable1(we1), .regWriteAddress1(wa1), .regWriteData1(wd1),
        .regReadAddress1(ra1), .regReadAddress2(ra2),
        .regReadData1(rd1_b), .regReadData2(rd2_b),
        .resvEnable(resv), .resvAddress(rsa),
        .regPending1(p1_b), .regPending2(p2_b), .pendingCount(cnt_b)
    );

    function automatic logic [7:0] exp_read(int cfg, int addr);
        if (cfg == 1 && addr == 0) return 8'h00;
        if (cfg == 0) begin
            if (we1 && int'(wa1) == addr) return wd1;
            if (we0 && int'(wa0) == addr) return wd0;
        end
        return mem_m[cfg][addr];
    endfunction

    function automatic int exp_count(int cfg);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(pend_m[cfg][i]);
        return n;
    endfunction

    function automatic void model_edge();
        for (int c = 0; c < 2; c++) begin
            if (reset) begin
                for (int i = 0; i < 16; i++) begin
                    mem_m[c][i]  = 8'h00;
                    pend_m[c][i] = 1'b0;
                end
            end else begin
                bit [15:0] written = '0;
                if (we0) begin mem_m[c][wa0] = wd0; written[wa0] = 1'b1; end
                if (we1) begin mem_m[c][wa1] = wd1; written[wa1] = 1'b1; end
                for (int i = 0; i < 16; i++) if (written[i]) pend_m[c][i] = 1'b0;
                if (resv) pend_m[c][rsa] = 1'b1;
                if (c == 1) begin
                    mem_m[c][0]  = 8'h00;
                    pend_m[c][0] = 1'b0;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; we0 = 1'b0; we1 = 1'b0; resv = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; rsa = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int a = 0; a < 16; a++) begin
            ra1 = reg_addr_t'(a);
            ra2 = reg_addr_t'(15 - a);
            #1;
            checks++;
            if (rd1_a !== 8'h00 || rd2_a !== 8'h00 || p1_a !== 1'b0 || p2_a !== 1'b0 ||
                cnt_a !== 5'd0) begin
                errors++;
                $display("FAIL reset_a addr %0d: got rd %h/%h pend %b/%b cnt %0d, want 00/00 0/0 0",
                         a, rd1_a, rd2_a, p1_a, p2_a, cnt_a);
            end
            checks++;
            if (rd1_b !== 8'h00 || rd2_b !== 8'h00 || p1_b !== 1'b0 || p2_b !== 1'b0 ||
                cnt_b !== 5'd0) begin
                errors++;
                $display("FAIL reset_b addr %0d: got rd %h/%h pend %b/%b cnt %0d, want 00/00 0/0 0",
                         a, rd1_b, rd2_b, p1_b, p2_b, cnt_b);
            end
        end
    endtask

    task automatic test_write_priority();
        idle_inputs();
        we0 = 1'b1; wa0 = 4'd3; wd0 = 8'hA5;
        we1 = 1'b1; wa1 = 4'd3; wd1 = 8'h5A;
        ra1 = 4'd0; ra2 = 4'd0;
        tick();
        idle_inputs();
        ra1 = 4'd3;
        #1;
        checks++;
        if (rd1_a !== 8'h5A) begin
            errors++;
            $display("FAIL prio_a: got %h want 5a", rd1_a);
        end
        checks++;
        if (rd1_b !== 8'h5A) begin
            errors++;
            $display("FAIL prio_b: got %h want 5a", rd1_b);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        we1 = 1'b1; wa1 = 4'd7; wd1 = 8'h3C;
        ra1 = 4'd7; ra2 = 4'd7;
        #1;
        checks++;
        if (rd1_a !== 8'h3C || rd2_a !== 8'h3C) begin
            errors++;
            $display("FAIL bypass_a: got %h/%h want 3c/3c", rd1_a, rd2_a);
        end
        checks++;
        if (rd1_b !== 8'h00) begin
            errors++;
            $display("FAIL nobypass_b: got %h want 00", rd1_b);
        end
        tick();
        idle_inputs();
        #1;
        checks++;
        if (rd1_a !== 8'h3C || rd1_b !== 8'h3C) begin
            errors++;
            $display("FAIL after_write: got %h/%h want 3c/3c", rd1_a, rd1_b);
        end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        we1 = 1'b1; wa1 = 4'd0; wd1 = 8'hFF;
        resv = 1'b1; rsa = 4'd0;
        tick();
        idle_inputs();
        ra1 = 4'd0; ra2 = 4'd0;
        #1;
        checks++;
        if (rd1_b !== 8'h00 || rd2_b !== 8'h00 || p1_b !== 1'b0 || cnt_b !== 5'd0) begin
            errors++;
            $display("FAIL zero_b: got rd %h pend %b cnt %0d, want 00 0 0", rd1_b, p1_b, cnt_b);
        end
        checks++;
        if (rd1_a !== 8'hFF || p1_a !== 1'b1 || cnt_a !== 5'd1) begin
            errors++;
            $display("FAIL nozero_a: got rd %h pend %b cnt %0d, want ff 1 1", rd1_a, p1_a, cnt_a);
        end
        // Retire the reservation in the non-zero build.
        we0 = 1'b1; wa0 = 4'd0; wd0 = 8'h00;
        tick();
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        ra1 = 4'd5; ra2 = 4'd9;
        resv = 1'b1; rsa = 4'd5;
        tick();
        checks++;
        if (cnt_a !== 5'd1 || cnt_b !== 5'd1 || p1_a !== 1'b1) begin
            errors++;
            $display("FAIL sb_resv5: got cnt %0d/%0d p5 %b, want 1/1 1", cnt_a, cnt_b, p1_a);
        end
        rsa = 4'd9;
        tick();
        checks++;
        if (cnt_a !== 5'd2 || cnt_b !== 5'd2 || p2_b !== 1'b1) begin
            errors++;
            $display("FAIL sb_resv9: got cnt %0d/%0d p9 %b, want 2/2 1", cnt_a, cnt_b, p2_b);
        end
        rsa = 4'd5;
        we0 = 1'b1; wa0 = 4'd5; wd0 = 8'h55;
        tick();
        checks++;
        if (cnt_a !== 5'd2 || cnt_b !== 5'd2 || p1_a !== 1'b1 || p1_b !== 1'b1) begin
            errors++;
            $display("FAIL sb_resv_wins: got cnt %0d/%0d p5 %b/%b, want 2/2 1/1",
                     cnt_a, cnt_b, p1_a, p1_b);
        end
        resv = 1'b0;
        wa0 = 4'd9; wd0 = 8'h99;
        tick();
        checks++;
        if (cnt_a !== 5'd1 || cnt_b !== 5'd1 || p2_a !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear9: got cnt %0d/%0d p9 %b, want 1/1 0", cnt_a, cnt_b, p2_a);
        end
        wa0 = 4'd5; wd0 = 8'h56;
        tick();
        checks++;
        if (cnt_a !== 5'd0 || cnt_b !== 5'd0 || p1_a !== 1'b0 || p1_b !== 1'b0) begin
            errors++;
            $display("FAIL sb_clear5: got cnt %0d/%0d p5 %b/%b, want 0/0 0/0",
                     cnt_a, cnt_b, p1_a, p1_b);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_reservation();
        idle_inputs();
        resv = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            rsa = reg_addr_t'(2 * i);
            tick();
        end
        resv = 1'b0;
        reset = 1'b1;
        we0 = 1'b1; wa0 = 4'd2; wd0 = 8'h11;
        tick();
        idle_inputs();
        ra1 = 4'd2; ra2 = 4'd4;
        #1;
        checks++;
        if (cnt_a !== 5'd0 || p1_a !== 1'b0 || p2_a !== 1'b0 || rd1_a !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_a: got cnt %0d pend %b/%b rd %h, want 0 0/0 00",
                     cnt_a, p1_a, p2_a, rd1_a);
        end
        checks++;
        if (cnt_b !== 5'd0 || p1_b !== 1'b0 || p2_b !== 1'b0 || rd1_b !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_b: got cnt %0d pend %b/%b rd %h, want 0 0/0 00",
                     cnt_b, p1_b, p2_b, rd1_b);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            we0   = $urandom_range(0, 1) == 1;
            we1   = $urandom_range(0, 2) == 0;
            resv  = $urandom_range(0, 1) == 1;
            // Small address window on some cycles to force collisions.
            if ($urandom_range(0, 1) == 1) begin
                wa0 = reg_addr_t'($urandom_range(0, 3));
                wa1 = reg_addr_t'($urandom_range(0, 3));
                rsa = reg_addr_t'($urandom_range(0, 3));
                ra1 = reg_addr_t'($urandom_range(0, 3));
                ra2 = reg_addr_t'($urandom_range(0, 3));
            end else begin
                wa0 = reg_addr_t'($urandom_range(0, 15));
                wa1 = reg_addr_t'($urandom_range(0, 15));
                rsa = reg_addr_t'($urandom_range(0, 15));
                ra1 = reg_addr_t'($urandom_range(0, 15));
                ra2 = reg_addr_t'($urandom_range(0, 15));
            end
            wd0 = reg_data_t'($urandom);
            wd1 = reg_data_t'($urandom);
            #1;
            checks++;
            if (rd1_a !== exp_read(0, ra1) || rd2_a !== exp_read(0, ra2)) begin
                errors++;
                $display("FAIL rand_rd_a cyc %0d: got %h/%h want %h/%h", n, rd1_a, rd2_a,
                         exp_read(0, ra1), exp_read(0, ra2));
            end
            checks++;
            if (rd1_b !== exp_read(1, ra1) || rd2_b !== exp_read(1, ra2)) begin
                errors++;
                $display("FAIL rand_rd_b cyc %0d: got %h/%h want %h/%h", n, rd1_b, rd2_b,
                         exp_read(1, ra1), exp_read(1, ra2));
            end
            checks++;
            if (p1_a !== pend_m[0][ra1] || p2_a !== pend_m[0][ra2] ||
                int'(cnt_a) != exp_count(0)) begin
                errors++;
                $display("FAIL rand_sb_a cyc %0d: got %b/%b cnt %0d want %b/%b cnt %0d", n,
                         p1_a, p2_a, cnt_a, pend_m[0][ra1], pend_m[0][ra2], exp_count(0));
            end
            checks++;
            if (p1_b !== pend_m[1][ra1] || p2_b !== pend_m[1][ra2] ||
                int'(cnt_b) != exp_count(1)) begin
                errors++;
                $display("FAIL rand_sb_b cyc %0d: got %b/%b cnt %0d want %b/%b cnt %0d", n,
                         p1_b, p2_b, cnt_b, pend_m[1][ra1], pend_m[1][ra2], exp_count(1));
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        ra1 = '0;
        ra2 = '0;
        @(negedge clk);
        test_reset();
        test_write_priority();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_reset_mid_reservation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
